// File: rtl/ezm_prog_seq.sv
// ezm_prog_seq: program sequencer for the 6-bit-instruction accumulator CPU.
// It holds a small program store that is loaded from pins while idle. Once a
// run starts, it releases the CPU from reset and feeds it one word per
// fetch/execute slot, indexed by the CPU's PC. A run ends on any of these:
// PC out of range, the instruction limit, or a stop request. The final
// accumulator is then captured into result_o.
// Optional build macro: BREAKPOINT_EN adds a PC breakpoint (bp_en_i, bp_addr_i,
// bp_hit_o).
module ezm_prog_seq #(
    parameter int ADDR_W    = 4,
    parameter int MAX_INSNS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cpu_out_i,
    output logic              cpu_rst_o,
    output logic [5:0]        cpu_instr_o,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [5:0]        data_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic              running_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [7:0]        result_o
`ifdef BREAKPOINT_EN
    ,
    input  logic              bp_en_i,
    input  logic [7:0]        bp_addr_i,
    output logic              bp_hit_o
`endif
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [7:0] MAX_CNT = 8'(MAX_INSNS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN_F   = 3'd1;
    localparam logic [2:0] S_RUN_E   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0] state_q, state_d;
    logic       cpu_rst_q, cpu_rst_d;
    logic [7:0] count_q, count_d;
    logic       timeout_q, timeout_d;
    logic       stop_q, stop_d;
    logic [5:0] held_q, held_d;
    logic [7:0] result_q, result_d;
    logic [5:0] instr_c;
    logic [5:0] mem_q [DEPTH];

    logic       pc_oob, lim_hit, bp_c, end_run, start_ok;
    logic [5:0] fetch_word;

    // A PC with any bit above the store range set (including wrap below 0) is
    // end-of-program.
    assign pc_oob     = (cpu_out_i >> ADDR_W) != 8'd0;
    assign lim_hit    = (count_q == MAX_CNT);
    assign fetch_word = mem_q[cpu_out_i[ADDR_W-1:0]];
    assign start_ok   = start_i && !load_i;

`ifdef BREAKPOINT_EN
    assign bp_c = bp_en_i && (cpu_out_i == bp_addr_i);
`else
    assign bp_c = 1'b0;
`endif

    assign end_run = pc_oob || lim_hit || stop_q || bp_c;

    // Next-state and instruction-bus decode for the run FSM.
    always_comb begin
        state_d   = state_q;
        cpu_rst_d = cpu_rst_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        stop_d    = stop_q;
        held_d    = held_q;
        result_d  = result_q;
        instr_c   = 6'd0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d   = S_RUN_F;
                    cpu_rst_d = 1'b0;
                    count_d   = 8'd0;
                    timeout_d = 1'b0;
                    stop_d    = 1'b0;
                end
            end
            S_RUN_F: begin
                stop_d = stop_q || stop_i;
                if (end_run) begin
                    // The CPU fetches a no-op, so the next cycle exposes the final accumulator.
                    state_d   = S_CAPTURE;
                    timeout_d = lim_hit && !pc_oob && !stop_q && !bp_c;
                end else begin
                    instr_c = fetch_word;
                    held_d  = fetch_word;
                    count_d = count_q + 8'd1;
                    state_d = S_RUN_E;
                end
            end
            S_RUN_E: begin
                // The CPU samples the operand field during execute, so keep the word stable.
                instr_c = held_q;
                stop_d  = stop_q || stop_i;
                state_d = S_RUN_F;
            end
            S_CAPTURE: begin
                result_d = cpu_out_i;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (start_i) begin
                    state_d   = S_IDLE;
                    cpu_rst_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    // FSM and run-status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cpu_rst_q <= 1'b1;
            count_q   <= 8'd0;
            timeout_q <= 1'b0;
            stop_q    <= 1'b0;
            held_q    <= 6'd0;
            result_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= cpu_rst_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            stop_q    <= stop_d;
            held_q    <= held_d;
            result_q  <= result_d;
        end
    end

    // Program store: cleared by reset, writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 6'd0;
        end else if (state_q == S_IDLE && load_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

`ifdef BREAKPOINT_EN
    logic bp_hit_q;

    // Breakpoint flag: set when a breakpoint ends the run, cleared on a new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit_q <= 1'b0;
        end else if (state_q == S_IDLE && start_ok) begin
            bp_hit_q <= 1'b0;
        end else if (state_q == S_RUN_F && bp_c) begin
            bp_hit_q <= 1'b1;
        end
    end

    assign bp_hit_o = bp_hit_q;
`endif

    assign cpu_rst_o   = cpu_rst_q;
    assign cpu_instr_o = instr_c;
    assign running_o   = (state_q == S_RUN_F) || (state_q == S_RUN_E) || (state_q == S_CAPTURE);
    assign done_o      = (state_q == S_DONE);
    assign timeout_o   = timeout_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ezm_prog_seq.sv
// tb_ezm_prog_seq: self-checking bench for ezm_prog_seq, with MAX_INSNS = 32.
// The bench contains a small two-phase accumulator CPU stand-in.
// Opcode is in [5:3] and immediate in [2:0]:
//   0 nop, 1 acc |= imm, 2 acc <<= imm, 3 pc += sext(imm), 4 acc = imm, 5..7 nop.
// Expected results come from an instruction-level program interpreter.
module tb_ezm_prog_seq;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXI   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_out;
    logic       cpu_rst;
    logic [5:0] cpu_instr;
    logic       load_i;
    logic [ADDR_W-1:0] addr_i;
    logic [5:0] data_i;
    logic       start_i, stop_i;
    logic       running, done, timeout;
    logic [7:0] result;
`ifdef BREAKPOINT_EN
    logic       bp_en;
    logic [7:0] bp_addr;
    logic       bp_hit;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ezm_prog_seq #(.ADDR_W(ADDR_W), .MAX_INSNS(MAXI)) dut (
        .clk(clk), .rst(rst), .cpu_out_i(cpu_out), .cpu_rst_o(cpu_rst),
        .cpu_instr_o(cpu_instr), .load_i(load_i), .addr_i(addr_i), .data_i(data_i),
        .start_i(start_i), .stop_i(stop_i), .running_o(running), .done_o(done),
        .timeout_o(timeout), .result_o(result)
`ifdef BREAKPOINT_EN
        , .bp_en_i(bp_en), .bp_addr_i(bp_addr), .bp_hit_o(bp_hit)
`endif
    );

    // CPU stand-in: fetch phase shows PC, execute phase shows acc and applies the word.
    logic [7:0] c_pc, c_acc;
    logic       c_ph;
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            c_pc <= 8'd0; c_acc <= 8'd0; c_ph <= 1'b0;
        end else if (!c_ph) begin
            c_ph <= 1'b1;
        end else begin
            c_ph <= 1'b0;
            c_pc <= c_pc + 8'd1;
            case (cpu_instr[5:3])
                3'd1: c_acc <= c_acc | {5'd0, cpu_instr[2:0]};
                3'd2: c_acc <= c_acc << cpu_instr[2:0];
                3'd3: c_pc  <= c_pc + {{5{cpu_instr[2]}}, cpu_instr[2:0]};
                3'd4: c_acc <= {5'd0, cpu_instr[2:0]};
                default: ;
            endcase
        end
    end
    assign cpu_out = c_ph ? c_acc : c_pc;

    typedef struct {
        logic [DEPTH-1:0][5:0] prog;
        int         stop_at;
        logic [7:0] exp_res;
        logic       exp_to;
        int         exp_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Interpreter: runs whole instructions until PC leaves the store, stop, or limit.
    function automatic void ref_run(input logic [DEPTH-1:0][5:0] p, input int stop_at,
                                    output logic [7:0] res, output logic to, output int n);
        int pc, sf, off;
        logic [7:0] acc;
        logic [5:0] w;
        pc = 0; acc = 8'd0; n = 0; to = 1'b0;
        sf = (stop_at > 0) ? (stop_at + 1) / 2 : 1000000;
        while (1) begin
            if (pc >= DEPTH || n >= sf) break;
            if (n == MAXI) begin to = 1'b1; break; end
            w = p[pc];
            n++;
            off = w[2] ? int'(w[2:0]) - 8 : int'(w[2:0]);
            case (w[5:3])
                3'd1: acc = acc | {5'd0, w[2:0]};
                3'd2: acc = acc << w[2:0];
                3'd4: acc = {5'd0, w[2:0]};
                default: ;
            endcase
            pc = (w[5:3] == 3'd3) ? ((pc + off) & 255) : ((pc + 1) & 255);
        end
        res = acc;
    endfunction

    task automatic load_prog(input logic [DEPTH-1:0][5:0] p);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            load_i = 1'b1; addr_i = ADDR_W'(a); data_i = p[a];
        end
        @(negedge clk);
        load_i = 1'b0;
    endtask

    // Start from IDLE; count running cycles until DONE.
    // stop_at/load_at name the cycle after start at which the pulse is applied.
    task automatic do_run(input int stop_at, input int load_at, output logic [7:0] res,
                          output logic to, output int rc, output bit ok);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        rc = 0; ok = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (running) rc++;
            stop_i = (i == stop_at);
            load_i = (i == load_at);
            addr_i = '0; data_i = 6'h3F;
            @(negedge clk);
        end
        stop_i = 1'b0; load_i = 1'b0;
        res = result; to = timeout;
    endtask

    task automatic run_chk(input string tag, input int stop_at, input int load_at,
                           input logic [7:0] er, input logic et, input int en);
        logic [7:0] r; logic t; int rc; bit ok;
        do_run(stop_at, load_at, r, t, rc, ok);
        chk({tag, "_done"}, 32'(ok), 32'd1);
        chk({tag, "_result"}, 32'(r), 32'(er));
        chk({tag, "_timeout"}, 32'(t), 32'(et));
        chk({tag, "_cycles"}, 32'(rc), 32'(2 * en + 2));
    endtask

    task automatic to_idle();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    vec_t vt[8];

    initial begin
        logic [DEPTH-1:0][5:0] p2, ploop, pw;
        logic [7:0] er; logic et; int en, sa;

        p2 = '0;    p2[0] = 6'h25;    p2[1] = 6'h09;    p2[2] = 6'h11;
        ploop = '0; ploop[0] = 6'h22; ploop[1] = 6'h08; ploop[2] = 6'h21; ploop[3] = 6'h18;
        pw = '0;    pw[0] = 6'h24;    pw[1] = 6'h1E;
        vt[0] = '{p2,    0,  8'h0A, 1'b0, 16};
        vt[1] = '{ploop, 0,  8'h01, 1'b1, 32};
        vt[2] = '{ploop, 10, 8'h01, 1'b0, 5};   // stop in 5th RUN_E
        vt[3] = '{pw,    0,  8'h04, 1'b0, 2};   // branch wraps PC to 255
        vt[4] = '{ploop, 9,  8'h01, 1'b0, 5};   // stop in 5th RUN_F
        vt[5] = '{ploop, 63, 8'h01, 1'b0, 32};  // stop and limit together
        vt[6] = '{ploop, 65, 8'h01, 1'b1, 32};  // stop in the ending RUN_F is ignored
        vt[7] = '{'0,    0,  8'h00, 1'b0, 16};
        vt[7].prog[0] = 6'h23; vt[7].prog[1] = 6'h12;
        vt[7].exp_res = 8'h0C;

        rst = 1'b1; load_i = 1'b1; addr_i = '0; data_i = 6'h3F;
        start_i = 1'b0; stop_i = 1'b0;
`ifdef BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 8'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_instr", 32'(cpu_instr), 32'd0);
        load_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Blank store straight out of reset.
        run_chk("blank", 0, 0, 8'h00, 1'b0, 16);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
        chk("done_instr", 32'(cpu_instr), 32'd0);
        chk("done_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("done_result", 32'(result), 32'd0);
        to_idle();

        // load and start together: write happens, run does not start.
        @(negedge clk);
        load_i = 1'b1; start_i = 1'b1; addr_i = '0; data_i = 6'h27;
        @(negedge clk);
        load_i = 1'b0; start_i = 1'b0;
        chk("ldst_running", 32'(running), 32'd0);
        chk("ldst_cpu_rst", 32'(cpu_rst), 32'd1);
        run_chk("ldst_run", 0, 0, 8'h07, 1'b0, 16);
        to_idle();

        for (int k = 0; k < 8; k++) begin
            load_prog(vt[k].prog);
            run_chk($sformatf("vec%0d", k), vt[k].stop_at, 0, vt[k].exp_res, vt[k].exp_to, vt[k].exp_n);
            to_idle();
        end

        // load during a run is ignored; a rerun gives the same result.
        load_prog(p2);
        run_chk("ldrun1", 0, 3, 8'h0A, 1'b0, 16);
        to_idle();
        @(negedge clk);
        stop_i = 1'b1;  // ignored in IDLE
        @(negedge clk);
        stop_i = 1'b0;
        run_chk("ldrun2", 0, 0, 8'h0A, 1'b0, 16);
        to_idle();

`ifdef BREAKPOINT_EN
        bp_en = 1'b1; bp_addr = 8'd2;
        run_chk("bp", 0, 0, 8'h05, 1'b0, 2);
        chk("bp_hit", 32'(bp_hit), 32'd1);
        to_idle();
        bp_en = 1'b0;
        run_chk("bp_off", 0, 0, 8'h0A, 1'b0, 16);
        chk("bp_clr", 32'(bp_hit), 32'd0);
        to_idle();
`endif

        // Randomized programs against the interpreter.
        for (int k = 0; k < 25; k++) begin
            logic [DEPTH-1:0][5:0] rp;
            for (int a = 0; a < DEPTH; a++) rp[a] = 6'($urandom_range(0, 63));
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0;
            ref_run(rp, sa, er, et, en);
            load_prog(rp);
            run_chk($sformatf("rnd%0d", k), sa, 0, er, et, en);
            to_idle();
        end

        // Reset mid-run clears everything, including the store.
        load_prog(ploop);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_running", 32'(running), 32'd0);
        chk("mrst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_chk("mrst_blank", 0, 0, 8'h00, 1'b0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
